tlb_wr_ctrl: RTL
================

Name: tlb_wr_ctrl

Overview:
- Sequences TLBWR/TLBFILL: reads the TLBEHI/TLBELO0/TLBELO1/TLBIDX/ASID CSR contents and issues one write to the TLB array.
- This is the CSR→TLB direction; TLBRD covers TLB→CSR.
- Sits between the commit stage (which issues requests) and the TLB array write port.
- Includes a free-running replacement counter that supplies the TLBFILL index.

Parameters:
- TLBNUM, 16, number of TLB entries; must be a power of 2.
- IDX_W, 4, index width, equal to log2(TLBNUM).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_vld  in  1  write request from commit
- req_op  in  1  0 = TLBWR, 1 = TLBFILL
- req_rdy  out  1  block idle, can accept a request
- flush  in  1  pipeline flush
- tlbehi_vpn  in  19  TLBEHI[31:13]
- tlbidx  in  32  TLBIDX CSR: index [IDX_W-1:0], PS [29:24], NE [31]
- tlbelo0  in  32  TLBELO0 CSR: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8]
- tlbelo1  in  32  TLBELO1 CSR, same layout as tlbelo0
- asid  in  10  ASID.ASID
- tlbr_active  in  1  ESTAT.Ecode == TLBR (refill in progress)
- tlb_we  out  1  TLB array write strobe
- tlb_w_index  out  IDX_W  entry to write
- tlb_w_e  out  1  entry exists bit
- tlb_w_vppn  out  19  VPPN to write
- tlb_w_ps  out  6  page size
- tlb_w_asid  out  10  ASID to write
- tlb_w_g  out  1  global bit
- tlb_w_lo0  out  26  packed {PPN[19:0], PLV, MAT, D, V} for even page
- tlb_w_lo1  out  26  same packing for odd page
- done  out  1  completion pulse to commit
- err  out  1  qualifies done: write suppressed because of invalid PS

Behaviour:
- Reset values:
  - state = IDLE; repl_cnt = 0.
  - All tlb_w_* outputs, tlb_we, done and err = 0.
  - req_rdy = 1.
- States: IDLE → CALC → WRITE → RESP → IDLE. All outputs are registered.
- repl_cnt:
  - Increments by 1 every clock in every state.
  - Wraps from TLBNUM-1 to 0.
- IDLE:
  - req_rdy = 1 only in IDLE.
  - Accept on req_vld && req_rdy && !flush. At that edge, capture all CSR inputs and req_op.
  - If req_op = 1, also capture repl_cnt (value before its increment).
  - Go to CALC.
- CALC (one cycle):
  - Index is the captured tlbidx[IDX_W-1:0] for TLBWR, or the captured repl_cnt for TLBFILL.
  - E = 1 if captured tlbr_active, else ~NE.
  - G = elo0.G & elo1.G.
  - lo0/lo1 packed from the CSR fields; vppn = vpn; ps and asid taken from the captured values.
  - PS valid only if it is 12 or 21.
  - Register the outputs and go to WRITE.
  - If flush is high during CALC: return to IDLE; no write, no done.
- WRITE (one cycle):
  - tlb_we = 1 for exactly this cycle if PS is valid; otherwise tlb_we stays 0.
  - flush is ignored from WRITE onward.
  - Go to RESP.
- RESP (one cycle):
  - done = 1; err = 1 if PS was invalid.
  - Go to IDLE.
- Latency: accept edge E0; tlb_we high during cycle E2–E3; done high during E3–E4; next accept possible at E4.
- tlb_w_* data:
  - Holds its values after the write until the next CALC.
  - Must be stable during any cycle in which tlb_we = 1.
- CSR inputs that change after accept do not affect the in-flight write (captured values are used).
- Accept edge with flush = 1: request not accepted; remain in IDLE.
- Asynchronous reset mid-operation:
  - Immediate return to IDLE with all reset values.
  - tlb_we drops with no partial write; no done is issued.

Test Plan:
- TLBWR, index=5, ps=12, NE=0, vpn=0x12345, elo0=0x0000_1153, elo1=0x0000_2141, asid=0x3A → tlb_we high 2 cycles after accept with index=5, e=1, g=1, vppn=0x12345, lo0 = {PPN 0x00011, PLV 0, MAT 1, D 1, V 1}; done high on the following cycle; err=0.
- TLBFILL accepted when repl_cnt=14, then again after wrap → first write uses index 14; the second uses a counter value that has wrapped through 15→0; the bench checks it against a reference counter.
- TLBWR with NE=1 and tlbr_active=1 → e=1; with tlbr_active=0 → e=0 and write still performed.
- TLBWR with ps=14 → tlb_we stays 0 throughout; done=1 with err=1.
- Flush asserted in CALC → no tlb_we, no done, req_rdy=1 next cycle. Flush asserted in WRITE → write and done both occur.
- rst_n pulsed low during WRITE → tlb_we falls immediately, no done, req_rdy=1 after reset release. Back-to-back requests → second accepted exactly 4 cycles after the first.

Source files
------------

// File: rtl/tlb_wr_ctrl.sv
// TLBWR/TLBFILL sequencer: captures the CSR image on accept and issues one TLB array write.
// All outputs are registered; repl_cnt free-runs to supply the TLBFILL victim index.
module tlb_wr_ctrl #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    input  logic             req_op,
    output logic             req_rdy,
    input  logic             flush,
    input  logic [18:0]      tlbehi_vpn,
    input  logic [31:0]      tlbidx,
    input  logic [31:0]      tlbelo0,
    input  logic [31:0]      tlbelo1,
    input  logic [9:0]       asid,
    input  logic             tlbr_active,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             tlb_w_e,
    output logic [18:0]      tlb_w_vppn,
    output logic [5:0]       tlb_w_ps,
    output logic [9:0]       tlb_w_asid,
    output logic             tlb_w_g,
    output logic [25:0]      tlb_w_lo0,
    output logic [25:0]      tlb_w_lo1,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StCalc, StWrite, StResp} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] repl_cnt_q;

    logic             op_q;
    logic             ne_q;
    logic             tlbr_q;
    logic [5:0]       ps_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] fill_q;
    logic [18:0]      vpn_q;
    logic [9:0]       asid_q;
    logic [25:0]      lo0_q;
    logic [25:0]      lo1_q;
    logic             g0_q;
    logic             g1_q;
    logic             ps_ok_q;

    // Array entry packing: {PPN, PLV, MAT, D, V}
    logic [25:0] lo0_pack;
    logic [25:0] lo1_pack;
    assign lo0_pack = {tlbelo0[27:8], tlbelo0[3:2], tlbelo0[5:4], tlbelo0[1:0]};
    assign lo1_pack = {tlbelo1[27:8], tlbelo1[3:2], tlbelo1[5:4], tlbelo1[1:0]};

    logic unused_csr;
    assign unused_csr = ^{tlbidx[30], tlbidx[23:IDX_W], tlbelo0[31:28], tlbelo0[7],
                          tlbelo1[31:28], tlbelo1[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            repl_cnt_q  <= '0;
            op_q        <= 1'b0;
            ne_q        <= 1'b0;
            tlbr_q      <= 1'b0;
            ps_q        <= '0;
            idx_q       <= '0;
            fill_q      <= '0;
            vpn_q       <= '0;
            asid_q      <= '0;
            lo0_q       <= '0;
            lo1_q       <= '0;
            g0_q        <= 1'b0;
            g1_q        <= 1'b0;
            ps_ok_q     <= 1'b0;
            req_rdy     <= 1'b1;
            tlb_we      <= 1'b0;
            tlb_w_index <= '0;
            tlb_w_e     <= 1'b0;
            tlb_w_vppn  <= '0;
            tlb_w_ps    <= '0;
            tlb_w_asid  <= '0;
            tlb_w_g     <= 1'b0;
            tlb_w_lo0   <= '0;
            tlb_w_lo1   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (repl_cnt_q == IDX_W'(TLBNUM - 1)) begin
                repl_cnt_q <= '0;
            end else begin
                repl_cnt_q <= repl_cnt_q + IDX_W'(1);
            end

            tlb_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req_vld && req_rdy && !flush) begin
                        op_q    <= req_op;
                        ne_q    <= tlbidx[31];
                        tlbr_q  <= tlbr_active;
                        ps_q    <= tlbidx[29:24];
                        idx_q   <= tlbidx[IDX_W-1:0];
                        vpn_q   <= tlbehi_vpn;
                        asid_q  <= asid;
                        lo0_q   <= lo0_pack;
                        lo1_q   <= lo1_pack;
                        g0_q    <= tlbelo0[6];
                        g1_q    <= tlbelo1[6];
                        if (req_op) begin
                            fill_q <= repl_cnt_q;
                        end
                        req_rdy <= 1'b0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (flush) begin
                        req_rdy <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tlb_w_index <= op_q ? fill_q : idx_q;
                        tlb_w_e     <= tlbr_q | ~ne_q;
                        tlb_w_vppn  <= vpn_q;
                        tlb_w_ps    <= ps_q;
                        tlb_w_asid  <= asid_q;
                        tlb_w_g     <= g0_q & g1_q;
                        tlb_w_lo0   <= lo0_q;
                        tlb_w_lo1   <= lo1_q;
                        ps_ok_q     <= (ps_q == 6'd12) || (ps_q == 6'd21);
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    // Strobe lands in the following cycle, with data already stable.
                    tlb_we  <= ps_ok_q;
                    state_q <= StResp;
                end
                StResp: begin
                    done    <= 1'b1;
                    err     <= ~ps_ok_q;
                    req_rdy <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
